ecc_write_encoder: RTL and testbench

ECC_WRITE_ENCODER -- requirements
Module: ecc_write_encoder

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/ecc_parity_gen.sv | 21 ++
 rtl/ecc_write_encoder.sv | 142 ++++++++++++++
 tb/tb_ecc_write_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants and types for the 64+8 SEC/DED write path.
// Used by ecc_parity_gen, ecc_write_encoder and the read-side scrubber.
package ecc_pkg;

  localparam int DATA_WIDTH  = 64;
  localparam int ECC_WIDTH   = 8;
  localparam int NUM_HAMMING = 6;

  // Bit k covers data bit i (i <= 62) when (i mod 2^(k+1)) lies in [2^k-1, 2^(k+1)-2].
  localparam logic [63:0] PARITY_MASK_0 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PARITY_MASK_1 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] PARITY_MASK_2 = 64'h7878_7878_7878_7878;
  localparam logic [63:0] PARITY_MASK_3 = 64'h7F80_7F80_7F80_7F80;
  localparam logic [63:0] PARITY_MASK_4 = 64'h7FFF_8000_7FFF_8000;
  localparam logic [63:0] PARITY_MASK_5 = 64'h7FFF_FFFF_8000_0000;

  localparam logic [NUM_HAMMING-1:0][63:0] PARITY_MASKS = {
    PARITY_MASK_5, PARITY_MASK_4, PARITY_MASK_3,
    PARITY_MASK_2, PARITY_MASK_1, PARITY_MASK_0
  };

  typedef struct packed {
    logic [ECC_WIDTH-1:0]  ecc;
    logic [DATA_WIDTH-1:0] data;
  } codeword_t;

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational check-bit generator: 6 masked parities, bit 63 copy, overall parity.
// Shared with the scrubber, so it carries no state.
module ecc_parity_gen
  import ecc_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ECC_WIDTH-1:0]  ecc
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HAMMING; gi++) begin : g_hamming
      assign ecc[gi] = ^(data & PARITY_MASKS[gi]);
    end
  endgenerate

  // Bit 63 sits alone in the seventh Hamming group, so its check bit is the bit itself.
  assign ecc[NUM_HAMMING]   = data[DATA_WIDTH-1];
  assign ecc[ECC_WIDTH-1]   = ^data;

endmodule

// File: rtl/ecc_write_encoder.sv
// Two-stage valid/ready ECC encoder: S1 holds raw data, S2 holds data plus check bits.
// Define ECC_ERR_INJECT_EN to add the one-shot fault injection ports.
module ecc_write_encoder #(
  parameter int DATA_WIDTH = ecc_pkg::DATA_WIDTH,
  parameter int ECC_WIDTH  = ecc_pkg::ECC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ECC_WIDTH-1:0]  out_ecc,
  output logic                  busy,
  output logic [15:0]           word_cnt
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic                  inj_arm,
  input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask,
  output logic                  inj_pending
`endif
);

  import ecc_pkg::*;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s2_valid_q, s2_valid_d;
  codeword_t             s2_cw_q, s2_cw_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  logic [ECC_WIDTH-1:0]  s1_ecc;
  codeword_t             s1_cw;
  logic                  s2_load;
  logic                  s1_load;
  logic                  s2_take;
  logic                  out_hs;

  ecc_parity_gen u_parity_gen (
    .data (s1_data_q),
    .ecc  (s1_ecc)
  );

`ifdef ECC_ERR_INJECT_EN
  logic      inj_pending_q, inj_pending_d;
  codeword_t inj_mask_q, inj_mask_d;
`endif

  always_comb begin
    s2_load     = ~s2_valid_q | out_ready;
    s1_load     = ~s1_valid_q | s2_load;
    s2_take     = s2_load & s1_valid_q;
    out_hs      = s2_valid_q & out_ready;
    s1_cw.ecc   = s1_ecc;
    s1_cw.data  = s1_data_q;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_cw_d    = s2_cw_q;
    word_cnt_d = word_cnt_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
      end
    end

    // Data registers only move when a real word arrives, so a stalled or drained S2 keeps its value.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_cw_d = s1_cw;
`ifdef ECC_ERR_INJECT_EN
        if (inj_pending_q) begin
          s2_cw_d = s1_cw ^ inj_mask_q;
        end
`endif
      end
    end

    if (out_hs && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

`ifdef ECC_ERR_INJECT_EN
  // A fresh arm wins over the clear, so a mask armed during an S2 load targets the next word.
  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_mask_d    = inj_mask_q;
    if (s2_take) begin
      inj_pending_d = 1'b0;
    end
    if (inj_arm) begin
      inj_pending_d = 1'b1;
      inj_mask_d    = inj_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_pending_q <= 1'b0;
      inj_mask_q    <= '0;
    end else begin
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
    end
  end

  assign inj_pending = inj_pending_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_cw_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_cw_q    <= s2_cw_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_cw_q.data;
  assign out_ecc   = s2_cw_q.ecc;
  assign busy      = s1_valid_q | s2_valid_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_ecc_write_encoder.sv
// Self-checking bench for ecc_write_encoder: vector table, scoreboard and corner sequences.
// Define ECC_ERR_INJECT_EN to also exercise the fault injection ports.
`timescale 1ns/1ps
module tb_ecc_write_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_ecc;
  logic        busy;
  logic [15:0] word_cnt;
`ifdef ECC_ERR_INJECT_EN
  logic        inj_arm = 1'b0;
  logic [71:0] inj_mask = '0;
  logic        inj_pending;
`endif

  ecc_write_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ecc   (out_ecc),
    .busy      (busy),
    .word_cnt  (word_cnt)
`ifdef ECC_ERR_INJECT_EN
    ,
    .inj_arm     (inj_arm),
    .inj_mask    (inj_mask),
    .inj_pending (inj_pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ecc;
  } vec_t;

  vec_t        vecs[8];
  logic [71:0] sb[$];
  int          checks = 0;
  int          failures = 0;
  int          in_hs = 0;
  int          out_hs = 0;
  int          cyc = 0;
  bit          verbose = 1'b1;
  int          inj_target = -1;
  logic [71:0] inj_target_mask = '0;

  function automatic logic [7:0] model_ecc(input logic [63:0] d);
    logic [7:0] e;
    int r, lo, hi;
    e = '0;
    for (int k = 0; k < 6; k++) begin
      lo = (1 << k) - 1;
      hi = (1 << (k + 1)) - 2;
      for (int i = 0; i < 63; i++) begin
        r = i % (1 << (k + 1));
        if (r >= lo && r <= hi) e[k] = e[k] ^ d[i];
      end
    end
    e[6] = d[63];
    e[7] = ^d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: expectation pushed at input handshake, compared at output handshake.
  always @(negedge clk) begin
    logic [71:0] exp;
    if (rst) begin
      sb.delete();
      in_hs  = 0;
      out_hs = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_ecc, out_data}, 72'hx);
        end else begin
          exp = sb.pop_front();
          chk("sb_word", {out_ecc, out_data}, exp);
          if (verbose) $display("out #%0d data=%h ecc=%h exp=%h", out_hs, out_data, out_ecc, exp);
        end
        out_hs++;
      end
      if (in_valid && in_ready) begin
        exp = {model_ecc(in_data), in_data};
        if (in_hs == inj_target) exp = exp ^ inj_target_mask;
        sb.push_back(exp);
        if (verbose) $display("in  #%0d data=%h", in_hs, in_data);
        in_hs++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge, in_valid left high.
  task automatic send(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (n < 200) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] held;
    int start;

    vecs[0] = '{64'h0, 8'h00};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h40};
    vecs[2] = '{64'h1, 8'h81};
    vecs[3] = '{64'h8000_0000_0000_0000, 8'hC0};
    for (int i = 4; i < 8; i++) begin
      vecs[i].data = {$urandom, $urandom};
      vecs[i].ecc  = model_ecc(vecs[i].data);
    end

    // Reset state, checked while rst is still asserted.
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_codeword", {out_ecc, out_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector table: one word at a time through an empty pipe.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].data);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_valid", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle2_valid", out_valid, 1);
      chk("vec_ecc", out_ecc, vecs[v].ecc);
      chk("vec_data", out_data, vecs[v].data);
      $display("vec %0d data=%h ecc=%h exp=%h", v, out_data, out_ecc, vecs[v].ecc);
      @(posedge clk);
      #1;
    end

    // Back-to-back burst: one word accepted per cycle.
    start = cyc;
    for (int i = 0; i < 16; i++) send({$urandom, $urandom});
    in_valid = 1'b0;
    chk("throughput_cycles", cyc - start, 16);
    drain();
    chk("word_cnt_24", word_cnt, 16'd24);

    // Stall: two words fill the pipe, the third waits until out_ready returns.
    out_ready = 1'b0;
    send(64'hAAAA_0000_0000_0001);
    send(64'hBBBB_0000_0000_0002);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_head_data", out_data, 64'hAAAA_0000_0000_0001);
    held = {out_ecc, out_data};
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {out_ecc, out_data}, held);
      chk("stall_in_ready_hold", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(64'hCCCC_0000_0000_0003);
    in_valid = 1'b0;
    drain();
    chk("word_cnt_27", word_cnt, 16'd27);

`ifdef ECC_ERR_INJECT_EN
    // One-shot injection of data bit 0 into the next word, then a clean word.
    inj_arm  = 1'b1;
    inj_mask = 72'h1;
    @(posedge clk);
    #1;
    inj_arm  = 1'b0;
    inj_mask = '0;
    chk("inj_pending_set", inj_pending, 1);
    inj_target      = in_hs;
    inj_target_mask = 72'h1;
    send(64'h0);
    send(64'h0);
    in_valid = 1'b0;
    drain();
    chk("inj_pending_clear", inj_pending, 0);
`endif

    // Reset with two words in flight: all cleared at once, nothing stale afterwards.
    out_ready = 1'b0;
    send(64'h1111_2222_3333_4444);
    send(64'h5555_6666_7777_8888);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Saturation: word_cnt must stick at 0xFFFF after 70000 handshakes.
    verbose = 1'b0;
    for (int i = 0; i < 70000; i++) send({32'h0, i});
    in_valid = 1'b0;
    drain();
    verbose = 1'b1;
    chk("word_cnt_saturate", word_cnt, 16'hFFFF);
    $display("saturation handshakes=%0d word_cnt=%h", out_hs, word_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
